// File: rtl/ddr4_interleave_sched.sv
// ddr4_interleave_sched: shares the single MIG app command port between a row-major
// write stream and a column-major read stream. Two DDR4 regions form a ping-pong
// buffer so one block can be written while the previous block is read back.
module ddr4_interleave_sched #(
  parameter int unsigned ADDR_WIDTH  = 29,
  parameter int unsigned MATRIX_ROW  = 8,
  parameter int unsigned MATRIX_COL  = 8,
  parameter int unsigned BURST_INC   = 8,
  parameter int unsigned RFIFO_DEPTH = 512
) (
  input  logic                  ui_clk,
  input  logic                  ui_clk_sync_rst,
  input  logic                  init_calib_complete,
  input  logic                  app_rdy,
  input  logic                  app_wdf_rdy,
  input  logic                  app_rd_data_valid,
  input  logic [8:0]            wfifo_rcount,
  input  logic [8:0]            rfifo_wcount,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic                  rfifo_wren,
  output logic                  blk_wr_done,
  output logic                  blk_rd_done,
  output logic [1:0]            buf_valid
);

  localparam int unsigned N      = MATRIX_ROW * MATRIX_COL;
  localparam int unsigned REGION = N * BURST_INC;
  localparam int unsigned RW     = (MATRIX_ROW > 1) ? $clog2(MATRIX_ROW) : 1;
  localparam int unsigned CW     = (MATRIX_COL > 1) ? $clog2(MATRIX_COL) : 1;
  // Outstanding reads never exceed one block: the next block waits for a drain to 0.
  localparam int unsigned OW     = $clog2(N + 1);

  localparam logic [RW-1:0] RowLast = RW'(MATRIX_ROW - 1);
  localparam logic [CW-1:0] ColLast = CW'(MATRIX_COL - 1);

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  // Registered state
  logic [0:0]            state_q, state_d;
  logic [RW-1:0]         wr_r_q, wr_r_d;
  logic [CW-1:0]         wr_c_q, wr_c_d;
  logic                  wsel_q, wsel_d;
  logic [RW-1:0]         rd_r_q, rd_r_d;
  logic [CW-1:0]         rd_c_q, rd_c_d;
  logic                  rsel_q, rsel_d;
  logic                  rd_all_q, rd_all_d;
  logic [OW-1:0]         outstanding_q, outstanding_d;
  logic                  prio_rd_q, prio_rd_d;
  logic [1:0]            buf_valid_q, buf_valid_d;
  logic                  blk_wr_done_q;
  logic                  blk_rd_done_q;
  logic [ADDR_WIDTH-1:0] last_addr_q;

  // Decode / arbitration signals
  logic                  running;
  logic                  wr_elig, rd_elig;
  logic                  wr_grant, rd_grant;
  logic                  wr_last, rd_last;
  logic                  rd_release;
  logic [31:0]           rd_occ;
  logic [31:0]           wr_off, rd_off;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

  // Command addresses derived from the current counters and region selects.
  always_comb begin
    wr_off = (32'(wr_r_q) * MATRIX_COL + 32'(wr_c_q)) * BURST_INC;
    if (wsel_q) wr_off = wr_off + REGION;
    rd_off = (32'(rd_r_q) * MATRIX_COL + 32'(rd_c_q)) * BURST_INC;
    if (rsel_q) rd_off = rd_off + REGION;
    wr_addr = ADDR_WIDTH'(wr_off);
    rd_addr = ADDR_WIDTH'(rd_off);
  end

  // Eligibility and round-robin arbitration between the two streams.
  always_comb begin
    running  = (state_q == StRun);
    wr_last  = (wr_r_q == RowLast) && (wr_c_q == ColLast);
    rd_last  = (rd_r_q == RowLast) && (rd_c_q == ColLast);
    // Keep room in the read FIFO for everything already requested but not returned.
    rd_occ   = 32'(rfifo_wcount) + 32'(outstanding_q);
    wr_elig  = running && !buf_valid_q[wsel_q] && (wfifo_rcount != 9'd0) &&
               app_rdy && app_wdf_rdy;
    rd_elig  = running && buf_valid_q[rsel_q] && !rd_all_q && app_rdy &&
               (rd_occ < (RFIFO_DEPTH - 2));
    // prio_rd_q is set when the read side lost the previous contested cycle.
    wr_grant = wr_elig && (!rd_elig || !prio_rd_q);
    rd_grant = rd_elig && (!wr_elig || prio_rd_q);
    rd_release = rd_all_q && (outstanding_q == '0);
  end

  // Next-state logic for the FSM, counters, outstanding tracker and buffer flags.
  always_comb begin
    state_d       = state_q;
    wr_r_d        = wr_r_q;
    wr_c_d        = wr_c_q;
    wsel_d        = wsel_q;
    rd_r_d        = rd_r_q;
    rd_c_d        = rd_c_q;
    rsel_d        = rsel_q;
    rd_all_d      = rd_all_q;
    outstanding_d = outstanding_q;
    prio_rd_d     = prio_rd_q;
    buf_valid_d   = buf_valid_q;

    case (state_q)
      StInit:  if (init_calib_complete) state_d = StRun;
      default: if (!init_calib_complete) state_d = StInit;
    endcase

    if (wr_elig && rd_elig) prio_rd_d = wr_grant;

    // Write side walks the block row-major: column first.
    if (wr_grant) begin
      if (wr_last) begin
        wr_r_d              = '0;
        wr_c_d              = '0;
        wsel_d              = !wsel_q;
        buf_valid_d[wsel_q] = 1'b1;
      end else if (wr_c_q == ColLast) begin
        wr_c_d = '0;
        wr_r_d = wr_r_q + 1'b1;
      end else begin
        wr_c_d = wr_c_q + 1'b1;
      end
    end

    // Read side walks the block column-major: row first.
    if (rd_grant) begin
      if (rd_last) begin
        rd_r_d   = '0;
        rd_c_d   = '0;
        rd_all_d = 1'b1;
      end else if (rd_r_q == RowLast) begin
        rd_r_d = '0;
        rd_c_d = rd_c_q + 1'b1;
      end else begin
        rd_r_d = rd_r_q + 1'b1;
      end
    end

    // Issue and return in the same cycle cancel; returns never drive it below 0.
    if (rd_grant && !app_rd_data_valid) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!rd_grant && app_rd_data_valid && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - 1'b1;
    end

    // Release targets rsel while a completing write targets wsel: never the same region.
    if (rd_release) begin
      buf_valid_d[rsel_q] = 1'b0;
      rsel_d              = !rsel_q;
      rd_all_d            = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      state_q       <= StInit;
      wr_r_q        <= '0;
      wr_c_q        <= '0;
      wsel_q        <= 1'b0;
      rd_r_q        <= '0;
      rd_c_q        <= '0;
      rsel_q        <= 1'b0;
      rd_all_q      <= 1'b0;
      outstanding_q <= '0;
      prio_rd_q     <= 1'b0;
      buf_valid_q   <= 2'b00;
      blk_wr_done_q <= 1'b0;
      blk_rd_done_q <= 1'b0;
      last_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_r_q        <= wr_r_d;
      wr_c_q        <= wr_c_d;
      wsel_q        <= wsel_d;
      rd_r_q        <= rd_r_d;
      rd_c_q        <= rd_c_d;
      rsel_q        <= rsel_d;
      rd_all_q      <= rd_all_d;
      outstanding_q <= outstanding_d;
      prio_rd_q     <= prio_rd_d;
      buf_valid_q   <= buf_valid_d;
      blk_wr_done_q <= wr_grant && wr_last;
      blk_rd_done_q <= rd_release;
      last_addr_q   <= app_addr;
    end
  end

  // Strobes are accepted in the cycle they are driven; address holds when idle.
  always_comb begin
    app_en       = wr_grant || rd_grant;
    app_cmd      = rd_grant ? 3'b001 : 3'b000;
    app_wdf_wren = wr_grant;
    app_wdf_end  = wr_grant;
    if (wr_grant)      app_addr = wr_addr;
    else if (rd_grant) app_addr = rd_addr;
    else               app_addr = last_addr_q;
    rfifo_wren   = app_rd_data_valid;
    blk_wr_done  = blk_wr_done_q;
    blk_rd_done  = blk_rd_done_q;
    buf_valid    = buf_valid_q;
  end

endmodule

// File: tb/tb_ddr4_interleave_sched.sv
// Testbench for ddr4_interleave_sched: directed phases with write/read address
// scoreboards, a delayed read-return model and a write-FIFO occupancy model.
module tb_ddr4_interleave_sched;

  localparam int AW = 29;

  logic          ui_clk = 1'b0;
  logic          ui_clk_sync_rst = 1'b1;
  logic          init_calib_complete = 1'b0;
  logic          app_rdy = 1'b1;
  logic          app_wdf_rdy = 1'b1;
  logic          app_rd_data_valid = 1'b0;
  logic [8:0]    wfifo_rcount = 9'd0;
  logic [8:0]    rfifo_wcount = 9'd0;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_wdf_wren, app_wdf_end, rfifo_wren;
  logic          blk_wr_done, blk_rd_done;
  logic [1:0]    buf_valid;

  ddr4_interleave_sched dut (
    .ui_clk             (ui_clk),
    .ui_clk_sync_rst    (ui_clk_sync_rst),
    .init_calib_complete(init_calib_complete),
    .app_rdy            (app_rdy),
    .app_wdf_rdy        (app_wdf_rdy),
    .app_rd_data_valid  (app_rd_data_valid),
    .wfifo_rcount       (wfifo_rcount),
    .rfifo_wcount       (rfifo_wcount),
    .app_addr           (app_addr),
    .app_cmd            (app_cmd),
    .app_en             (app_en),
    .app_wdf_wren       (app_wdf_wren),
    .app_wdf_end        (app_wdf_end),
    .rfifo_wren         (rfifo_wren),
    .blk_wr_done        (blk_wr_done),
    .blk_rd_done        (blk_rd_done),
    .buf_valid          (buf_valid)
  );

  always #5 ui_clk = ~ui_clk;

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] wr_q[$];
  logic [AW-1:0] rd_q[$];
  int            ret_q[$];
  logic [AW-1:0] last_addr;
  int  cyc = 0;
  int  wr_cnt, rd_cnt, wren_cnt, wdone_cnt, rdone_cnt;
  int  wr_first_cyc, wr_last_cyc;
  int  alt_cnt;
  bit  alt_arm, phase3, ret_en, toggle_rdy, wrote_now;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] waddr(input int base, input int i);
    return AW'(base * 512 + i * 8);
  endfunction

  // Column-major read order: row index moves fastest.
  function automatic logic [AW-1:0] raddr(input int base, input int k);
    return AW'(base * 512 + ((k % 8) * 8 + (k / 8)) * 8);
  endfunction

  task automatic push_block(input int base);
    for (int i = 0; i < 64; i++) wr_q.push_back(waddr(base, i));
    for (int k = 0; k < 64; k++) rd_q.push_back(raddr(base, k));
  endtask

  // Called at the negedge: compare the combinational outputs of this cycle.
  task automatic monitor();
    logic [AW-1:0] exp;
    wrote_now = 1'b0;
    check("rfifo_wren", rfifo_wren, app_rd_data_valid);
    if (rfifo_wren) wren_cnt++;
    if (blk_wr_done) wdone_cnt++;
    if (blk_rd_done) rdone_cnt++;
    if (app_en === 1'b1) begin
      if (app_cmd === 3'b000) begin
        check("wr_gate", {app_rdy, app_wdf_rdy, wfifo_rcount != 9'd0}, 3'b111);
        check("wr_strobes", {app_wdf_wren, app_wdf_end}, 2'b11);
        check("wr_expected", wr_q.size() != 0, 1'b1);
        if (wr_q.size() != 0) begin
          exp = wr_q.pop_front();
          check("wr_addr", app_addr, exp);
          last_addr = exp;
        end
        if (wr_cnt == 0) wr_first_cyc = cyc;
        wr_last_cyc = cyc;
        wr_cnt++;
        wrote_now = 1'b1;
        if (phase3 && wr_cnt == 129) check("blk2_after_release", rdone_cnt >= 1, 1'b1);
      end else if (app_cmd === 3'b001) begin
        check("rd_strobes", {app_wdf_wren, app_wdf_end}, 2'b00);
        check("rd_expected", rd_q.size() != 0, 1'b1);
        if (rd_q.size() != 0) begin
          exp = rd_q.pop_front();
          check("rd_addr", app_addr, exp);
          last_addr = exp;
        end
        rd_cnt++;
        if (ret_en) ret_q.push_back(cyc + 20);
      end else begin
        check("cmd_legal", app_cmd, 3'b000);
      end
    end else begin
      check("idle_outputs", {app_cmd, app_wdf_wren, app_wdf_end, app_addr},
            {3'b000, 1'b0, 1'b0, last_addr});
    end
    if (phase3 && blk_wr_done && wdone_cnt == 1) begin
      alt_arm = 1'b1;
      alt_cnt = 0;
    end
    if (alt_arm) begin
      check("alternate", {app_en, app_cmd}, {1'b1, (alt_cnt % 2 == 1) ? 3'b001 : 3'b000});
      alt_cnt++;
      if (alt_cnt == 128) alt_arm = 1'b0;
    end
  endtask

  // One clock: sample at negedge, then update inputs just after the rising edge.
  task automatic tick();
    @(negedge ui_clk);
    monitor();
    @(posedge ui_clk);
    #1;
    cyc++;
    if (wrote_now) wfifo_rcount = wfifo_rcount - 9'd1;
    app_rd_data_valid = 1'b0;
    if (ret_q.size() != 0 && ret_q[0] <= cyc) begin
      void'(ret_q.pop_front());
      app_rd_data_valid = 1'b1;
    end
    if (toggle_rdy) app_rdy = ~app_rdy;
  endtask

  task automatic do_reset();
    ui_clk_sync_rst = 1'b1;
    app_rd_data_valid = 1'b0;
    wr_q.delete();
    rd_q.delete();
    ret_q.delete();
    last_addr = '0;
    wr_cnt = 0; rd_cnt = 0; wren_cnt = 0; wdone_cnt = 0; rdone_cnt = 0;
    alt_arm = 1'b0; alt_cnt = 0;
    #1;
    check("rst_outputs", {app_en, app_wdf_wren, app_wdf_end, app_cmd, app_addr,
                          blk_wr_done, blk_rd_done, buf_valid}, 64'd0);
    repeat (2) @(posedge ui_clk);
    #1;
    ui_clk_sync_rst = 1'b0;
  endtask

  function automatic int done_cnt(input bit rd);
    return rd ? rdone_cnt : wdone_cnt;
  endfunction

  task automatic wait_done(input string tag, input bit rd, input int target, input int budget);
    int n = 0;
    while (done_cnt(rd) < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, done_cnt(rd) >= target, 1'b1);
  endtask

  initial begin
    int n;
    // Calibration held low: no command may issue.
    do_reset();
    wfifo_rcount = 9'd64;
    ret_en = 1'b1;
    push_block(0);
    repeat (100) tick();
    check("no_cmd_before_calib", wr_cnt + rd_cnt, 0);
    init_calib_complete = 1'b1;
    wait_done("blk0_wr_timeout", 1'b0, 1, 300);
    check("blk0_buf_valid", buf_valid, 2'b01);
    check("blk0_wr_count", wr_cnt, 64);
    check("blk0_wr_consecutive", wr_last_cyc - wr_first_cyc, 63);
    // Read-back of region 0 with returns 20 cycles after each read.
    wait_done("blk0_rd_timeout", 1'b1, 1, 1000);
    check("blk0_rfifo_wren", wren_cnt, 64);
    check("blk0_rd_count", rd_cnt, 64);
    check("blk0_buf_empty", buf_valid, 2'b00);
    check("blk0_single_wr_done", wdone_cnt, 1);
    check("blk0_wq_drained", wr_q.size(), 0);
    check("blk0_rq_drained", rd_q.size(), 0);

    // Three blocks of continuous traffic: ping-pong bases 0, 512, 0.
    do_reset();
    phase3 = 1'b1;
    wfifo_rcount = 9'd192;
    push_block(0);
    push_block(1);
    push_block(0);
    wait_done("stream_timeout", 1'b1, 3, 3000);
    check("stream_wr_done", wdone_cnt, 3);
    check("stream_alt_len", alt_cnt, 128);
    check("stream_wq_drained", wr_q.size(), 0);
    check("stream_rq_drained", rd_q.size(), 0);
    phase3 = 1'b0;

    // Read-FIFO back-pressure with reads never returned.
    do_reset();
    ret_en = 1'b0;
    wfifo_rcount = 9'd64;
    rfifo_wcount = 9'd501;
    push_block(0);
    wait_done("bp_wr_timeout", 1'b0, 1, 300);
    repeat (50) tick();
    check("bp_rd_limit", rd_cnt, 9);
    rfifo_wcount = 9'd495;
    repeat (30) tick();
    check("bp_rd_resume", rd_cnt, 15);
    rfifo_wcount = 9'd0;

    // app_rdy toggling every cycle, app_wdf_rdy low for 5 cycles.
    do_reset();
    ret_en = 1'b1;
    wfifo_rcount = 9'd64;
    push_block(0);
    toggle_rdy = 1'b1;
    n = 0;
    while (rdone_cnt < 1 && n < 2000) begin
      app_wdf_rdy = !(n >= 10 && n < 15);
      tick();
      n++;
    end
    check("rdy_timeout", rdone_cnt >= 1, 1'b1);
    toggle_rdy = 1'b0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    check("rdy_wr_count", wr_cnt, 64);
    check("rdy_rd_count", rd_cnt, 64);
    check("rdy_wq_drained", wr_q.size(), 0);
    check("rdy_rq_drained", rd_q.size(), 0);

    // Reset in the middle of a block discards it; the next block starts at 0.
    do_reset();
    wfifo_rcount = 9'd64;
    push_block(0);
    n = 0;
    while (wr_cnt < 30 && n < 200) begin
      tick();
      n++;
    end
    check("partial_wr_count", wr_cnt, 30);
    do_reset();
    wfifo_rcount = 9'd64;
    push_block(0);
    ret_q.push_back(cyc + 2);
    wait_done("post_rst_timeout", 1'b1, 1, 1000);
    check("post_rst_wr_count", wr_cnt, 64);
    check("post_rst_rfifo_wren", wren_cnt, 65);
    check("post_rst_buf_empty", buf_valid, 2'b00);
    check("post_rst_wq_drained", wr_q.size(), 0);
    check("post_rst_rq_drained", rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
